// File: rtl/lc_pkg.sv
// ---------------------------------------------------------------------------
// lc_pkg
// Shared types and constants for the lc operand feeder.
//   lc_data_t        : one signed 32-bit operand, passed through bit-exact
//   lc_pair_t        : one (a, b) operand pair as stored in the FIFO
//   lc_feed_state_t  : burst sequencer states
//   LC_CNT_W         : width of the element/gap counters and vec_count
//   lc_cnt_w()       : width of a FIFO occupancy count for a given depth
// ---------------------------------------------------------------------------
package lc_pkg;

    typedef int lc_data_t;

    typedef struct packed {
        lc_data_t a;
        lc_data_t b;
    } lc_pair_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } lc_feed_state_t;

    localparam int LC_CNT_W = 16;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int lc_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lc_feeder_if.sv
// ---------------------------------------------------------------------------
// lc_feeder_if
// Bundles the operand-source handshake and the MAC-chain operand stream of
// the lc feeder.
//   enable                : permission to start a new burst
//   in_valid/in_ready     : source handshake, pair taken when both high
//   in_a/in_b             : incoming operand pair
//   a_out/b_out           : operands toward the lc stage (0 when idle)
//   out_valid/first/last  : burst framing for a_out/b_out
//   vec_done/vec_count    : completion pulse and completed-vector counter
// Modports:
//   master : the side that supplies operands and observes the stream
//   slave  : the feeder itself
// ---------------------------------------------------------------------------
interface lc_feeder_if;
    import lc_pkg::*;

    logic                enable;
    logic                in_valid;
    logic                in_ready;
    lc_data_t            in_a;
    lc_data_t            in_b;
    lc_data_t            a_out;
    lc_data_t            b_out;
    logic                out_valid;
    logic                out_first;
    logic                out_last;
    logic                vec_done;
    logic [LC_CNT_W-1:0] vec_count;

    modport master (
        output enable,
        output in_valid,
        output in_a,
        output in_b,
        input  in_ready,
        input  a_out,
        input  b_out,
        input  out_valid,
        input  out_first,
        input  out_last,
        input  vec_done,
        input  vec_count
    );

    modport slave (
        input  enable,
        input  in_valid,
        input  in_a,
        input  in_b,
        output in_ready,
        output a_out,
        output b_out,
        output out_valid,
        output out_first,
        output out_last,
        output vec_done,
        output vec_count
    );

endinterface

// File: rtl/lc_fifo.sv
// ---------------------------------------------------------------------------
// lc_fifo
// Synchronous FIFO of (a, b) operand pairs with a registered read port so the
// storage array maps onto block RAM.
//   clk, rst : clock and synchronous active-high reset (empties the FIFO)
//   push     : write wr_data; ignored when full
//   pop      : read the head into rd_data on the next cycle; ignored when empty
//   wr_data  : pair to store
//   rd_data  : registered head pair, updated only on an accepted pop
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : registered occupancy, 0..DEPTH
// A refused push at full is refused even if a pop is accepted in the same
// cycle, because full is decoded from the registered count.
// ---------------------------------------------------------------------------
module lc_fifo
    import lc_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CNT_W = lc_cnt_w(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  lc_pair_t         wr_data,
    output lc_pair_t         rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    lc_pair_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    lc_pair_t         rd_data_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_reg;
    assign rd_data = rd_data_reg;

    // Explicit modulo-DEPTH wrap keeps DEPTH=1 legal as well.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage array: no reset so it stays a plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Registered read. A pop never targets the slot being written in the same
    // cycle, because pops only occur while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (pop_ok) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

endmodule

// File: rtl/lc_feeder.sv
// ---------------------------------------------------------------------------
// lc_feeder
// Operand sequencer in front of the two-tap MAC chain. Buffers (a, b) pairs
// and, once a full vector of VEC_LEN pairs is buffered and enable is high,
// streams it one pair per cycle, then holds zeros for GAP_CYCLES cycles so the
// chain can drain, then pulses vec_done and bumps vec_count.
//   clk, rst : clock and synchronous active-high reset (aborts any burst)
//   bus      : lc_feeder_if.slave
//              enable, in_valid/in_ready, in_a/in_b      (source side)
//              a_out/b_out, out_valid/out_first/out_last (MAC side)
//              vec_done, vec_count                       (status)
// Every output is registered, so the visible stream lags the internal state
// by one cycle: a pair popped in cycle t is presented in cycle t+1, and the
// DONE state shows up as vec_done one cycle later.
// ---------------------------------------------------------------------------
module lc_feeder
    import lc_pkg::*;
#(
    parameter int VEC_LEN    = 8,
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 4
) (
    input logic        clk,
    input logic        rst,
    lc_feeder_if.slave bus
);

    localparam int CNT_W = lc_cnt_w(DEPTH);
    localparam logic [LC_CNT_W-1:0] ELEM_LAST = LC_CNT_W'(VEC_LEN - 1);
    localparam logic [LC_CNT_W-1:0] GAP_LAST  =
        LC_CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    // FIFO connection
    lc_pair_t         wr_pair;
    lc_pair_t         rd_pair;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             push;
    logic             pop;
    logic             stream_pop;

    // Sequencer state
    lc_feed_state_t      state_reg;
    lc_feed_state_t      state_next;
    logic [LC_CNT_W-1:0] elem_reg;
    logic [LC_CNT_W-1:0] elem_next;
    logic [LC_CNT_W-1:0] gap_reg;
    logic [LC_CNT_W-1:0] gap_next;
    logic                start_ok;

    // Registered outputs
    logic                out_valid_reg;
    logic                out_first_reg;
    logic                out_last_reg;
    logic                vec_done_reg;
    logic [LC_CNT_W-1:0] vec_count_reg;

    // in_ready depends on the registered occupancy only, never on a pop in
    // flight, so the source sees a clean registered-style ready.
    assign bus.in_ready = !fifo_full;
    assign push         = bus.in_valid && !fifo_full;
    assign wr_pair.a    = bus.in_a;
    assign wr_pair.b    = bus.in_b;

    lc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_pair),
        .rd_data (rd_pair),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A burst is only launched with the whole vector already buffered, so
    // the chain never sees a bubble inside a vector.
    assign start_ok = bus.enable && (fifo_count >= CNT_W'(VEC_LEN));

    // STREAM never underflows given start_ok; the empty guard is defensive.
    assign pop = stream_pop && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            elem_reg  <= '0;
            gap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            elem_reg  <= elem_next;
            gap_reg   <= gap_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        elem_next  = elem_reg;
        gap_next   = gap_reg;
        stream_pop = 1'b0;
        case (state_reg)
            IDLE: begin
                elem_next = '0;
                gap_next  = '0;
                if (start_ok) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                stream_pop = 1'b1;
                if (elem_reg == ELEM_LAST) begin
                    elem_next  = '0;
                    state_next = (GAP_CYCLES == 0) ? DONE : GAP;
                end else begin
                    elem_next = elem_reg + 1'b1;
                end
            end
            GAP: begin
                if (gap_reg == GAP_LAST) begin
                    gap_next   = '0;
                    state_next = DONE;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end
            DONE: begin
                // Always return through IDLE so bursts are separated.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_first_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            vec_done_reg  <= 1'b0;
            vec_count_reg <= '0;
        end else begin
            out_valid_reg <= pop;
            out_first_reg <= pop && (elem_reg == '0);
            out_last_reg  <= pop && (elem_reg == ELEM_LAST);
            vec_done_reg  <= (state_reg == DONE);
            if (state_reg == DONE) begin
                vec_count_reg <= vec_count_reg + 1'b1;
            end
        end
    end

    // The FIFO read register holds its last value after a burst, so each
    // operand lane is forced to zero whenever the stream is not valid; the
    // MAC accumulators then see +0 while idle or draining.
    logic [1:0][31:0] rd_lanes;
    logic [1:0][31:0] out_lanes;

    assign rd_lanes = {rd_pair.a, rd_pair.b};

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign out_lanes[gi] = out_valid_reg ? rd_lanes[gi] : 32'd0;
    end

    assign bus.a_out     = out_lanes[1];
    assign bus.b_out     = out_lanes[0];
    assign bus.out_valid = out_valid_reg;
    assign bus.out_first = out_first_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.vec_done  = vec_done_reg;
    assign bus.vec_count = vec_count_reg;

endmodule
